// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 VGA raster timing with pixel, line and frame strobes
module vga_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic [9:0] pixelx,
  output logic [9:0] pixely,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing: raster totals exceed 10-bit counters");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic             x_end;
  logic             y_end;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;

  // Flags are registered from the next counter values so they line up with pixelx/pixely.
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    x_end    = (pixelx == H_LAST);
    y_end    = (pixely == V_LAST);
    x_nxt    = pixelx;
    y_nxt    = pixely;
    if (div_wrap) begin
      x_nxt = x_end ? 10'd0 : pixelx + 10'd1;
      if (x_end) begin
        y_nxt = y_end ? 10'd0 : pixely + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      pixel_tick  <= 1'b0;
      pixelx      <= 10'd0;
      pixely      <= 10'd0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      pixel_tick  <= div_wrap;
      pixelx      <= x_nxt;
      pixely      <= y_nxt;
      hsync       <= (x_nxt >= HS_START && x_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (y_nxt >= VS_START && y_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
      video_on    <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      line_start  <= div_wrap && x_end;
      frame_start <= div_wrap && x_end && y_end;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing on a reduced raster, two builds
module tb_vga_timing;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tick0, hs0, vs0, von0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       tick1, hs1, vs1, von1, ls1, fs1;
  logic [9:0] x1, y1;

  vga_timing #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) u_dut_div2 (
    .clk(clk), .rst(rst), .pixel_tick(tick0), .pixelx(x0), .pixely(y0),
    .hsync(hs0), .vsync(vs0), .video_on(von0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) u_dut_div1 (
    .clk(clk), .rst(rst), .pixel_tick(tick1), .pixelx(x1), .pixely(y1),
    .hsync(hs1), .vsync(vs1), .video_on(von1), .line_start(ls1), .frame_start(fs1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Closed-form expectation: k clock edges after reset release.
  function automatic logic [25:0] model(input int k, input int div, input bit pol);
    int  n, p, x, y;
    bit  tick, hs, vs, von, ls, fs;
    tick = (k > 0) && (k % div == 0);
    n    = k / div;
    p    = n % (HT * VT);
    x    = p % HT;
    y    = p / HT;
    hs   = (x >= HA + HF && x < HA + HF + HS) ? pol : !pol;
    vs   = (y >= VA + VF && y < VA + VF + VS) ? pol : !pol;
    von  = (x < HA) && (y < VA);
    ls   = tick && (x == 0);
    fs   = ls && (y == 0);
    return {tick, 10'(x), 10'(y), hs, vs, von, ls, fs};
  endfunction

  logic [25:0] q0[$];
  logic [25:0] q1[$];
  int          k = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) k = 0;
      else k++;
      q0.push_back(model(k, 2, 1'b0));
      q1.push_back(model(k, 1, 1'b1));
      @(negedge clk);
      check("div2", {tick0, x0, y0, hs0, vs0, von0, ls0, fs0}, q0.pop_front());
      check("div1_pol1", {tick1, x1, y1, hs1, vs1, von1, ls1, fs1}, q1.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (1500) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2300) @(negedge clk);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
